alu_instr_sequencer: RTL

- Instruction-issuing front end for the 16-bit combinational ALU (4-bit sel opcodes).
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU's A, B and sel inputs, captures the ALU result, writes it back, and presents it on a valid/ready result port.
- Sits between the fetch/control logic and the ALU; the ALU itself stays external.

---
 rtl/alu_instr_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_instr_sequencer.sv
// Instruction sequencer for an external 16-bit ALU: owns an 8x16
// register file, issues one instruction at a time, returns results.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   instr_valid/ready, instr    instruction handshake and word
//   alu_a, alu_b, alu_sel       registered ALU operands/opcode
//   alu_result                  ALU combinational result
//   res_valid/ready, res_data   result handshake and value
//   res_err                     00 ok, 01 illegal op, 10 div by zero
//   dbg_addr, dbg_data          combinational register-file read
module alu_instr_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [15:0] RESET_VAL   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [3:0] OP_LI  = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0111;

  localparam logic [3:0] CNT_INIT =
    4'(EXEC_CYCLES - 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  state_t      state;
  logic [15:0] rf [8];
  logic [15:0] iw;
  logic [3:0]  cnt;
  logic [15:0] val;
  logic [1:0]  err;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic        is_li;
  logic        is_alu;

  assign op = iw[15:12];
  assign rd = iw[11:9];
  assign rs = iw[8:6];
  assign rt = iw[5:3];

  assign is_li = (op == OP_LI);

  always_comb begin
    is_alu = 1'b0;
    case (op)
      4'b0001, 4'b0011, 4'b0101,
      4'b0111, 4'b1101, 4'b1111,
      4'b1001, 4'b1011, 4'b1010:
        is_alu = 1'b1;
      default:
        is_alu = 1'b0;
    endcase
  end

  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= 16'h0000;
      res_err     <= ERR_OK;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
      alu_sel     <= 4'b0000;
      iw          <= 16'h0000;
      cnt         <= 4'd0;
      val         <= 16'h0000;
      err         <= ERR_OK;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= RESET_VAL;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            iw          <= instr;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end

        DECODE: begin
          alu_a <= rf[rs];
          alu_b <= rf[rt];
          unique case (1'b1)
            is_li: begin
              alu_sel <= 4'b0000;
              val     <= {7'b0, iw[8:0]};
              err     <= ERR_OK;
              state   <= WB;
            end
            is_alu: begin
              alu_sel <= op;
              cnt     <= CNT_INIT;
              state   <= EXEC;
            end
            default: begin
              alu_sel <= 4'b0000;
              val     <= 16'h0000;
              err     <= ERR_ILL;
              state   <= WB;
            end
          endcase
        end

        EXEC: begin
          if (cnt == 4'd0) begin
            // divide by zero overrides whatever the ALU returns
            if (op == OP_DIV && alu_b == 16'h0000) begin
              val <= 16'hFFFF;
              err <= ERR_DIV0;
            end else begin
              val <= alu_result;
              err <= ERR_OK;
            end
            state <= WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WB: begin
          // first WB cycle commits; later cycles wait for the consumer
          if (!res_valid) begin
            if (err != ERR_ILL) begin
              rf[rd] <= val;
            end
            res_data  <= val;
            res_err   <= err;
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
